// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling UART receiver with a one-entry holding register.
//
// Decodes frames of 5-8 data bits (LSB first), optional even/odd parity and
// 1 or 2 stop bits. Each decoded character is offered through rx_data with
// a rx_valid/rx_ready handshake. Parity, framing and overrun errors are
// reported alongside the held character.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   rx           serial input, asynchronous, idles high
//   data_bit_num data bits: 00=5, 01=6, 10=7, 11=8
//   stop_bit_num 0 = one stop bit, 1 = two stop bits
//   parity_en    parity bit present
//   parity_type  1 = even, 0 = odd
//   rx_ready     consumer accepts the held character
//   rx_data      held character, LSB-aligned, unused upper bits 0
//   rx_valid     holding register full
//   parity_err   parity mismatch on the held character
//   frame_err    a stop bit of the held character was sampled 0
//   overrun_err  a frame was dropped because the holding register was full
//   rts_n        flow control, 0 = ready to receive (mirrors rx_valid)
module uart_rx #(
  parameter int BAUD_RATE     = 115200,
  parameter int FREQUENCY_CLK = 50000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  input  logic [1:0] data_bit_num,
  input  logic       stop_bit_num,
  input  logic       parity_en,
  input  logic       parity_type,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       rts_n
);

  localparam int DIV_RAW = FREQUENCY_CLK / (BAUD_RATE * 16);
  localparam int DIV     = (DIV_RAW < 2) ? 2 : DIV_RAW;
  localparam int DW      = $clog2(DIV);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } state_t;

  state_t      state;
  logic        rx_meta;
  logic        rx_s;
  logic        rx_q;
  logic [DW-1:0] div_cnt;
  logic [3:0]  tcnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        parity_bad;
  logic        frame_bad;

  // Frame format captured at the validated start bit, so configuration
  // changes mid-frame only affect the next frame.
  logic [1:0]  data_bits_sh;
  logic        stop2_sh;
  logic        par_en_sh;
  logic        par_type_sh;

  logic        tick;
  logic        sample;
  logic        complete;
  logic        frame_new;
  logic        par_expected;
  logic [2:0]  last_idx;

  assign tick         = (state != IDLE) && (div_cnt == DW'(DIV - 1));
  // Mid-bit point of every bit after the start bit.
  assign sample       = tick && (tcnt == 4'd15);
  assign complete     = sample && (((state == STOP1) && !stop2_sh) || (state == STOP2));
  // Frame error of the completing frame includes the stop bit sampled now.
  assign frame_new    = frame_bad | ~rx_s;
  // Unused upper bits of shift are 0, so the 8-bit reduction covers N bits.
  assign par_expected = par_type_sh ? ^shift : ~^shift;
  assign last_idx     = 3'd4 + {1'b0, data_bits_sh};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      rx_meta      <= 1'b1;
      rx_s         <= 1'b1;
      rx_q         <= 1'b1;
      div_cnt      <= '0;
      tcnt         <= 4'd0;
      bit_cnt      <= 3'd0;
      shift        <= 8'd0;
      parity_bad   <= 1'b0;
      frame_bad    <= 1'b0;
      data_bits_sh <= 2'd3;
      stop2_sh     <= 1'b0;
      par_en_sh    <= 1'b0;
      par_type_sh  <= 1'b0;
      rx_data      <= 8'd0;
      rx_valid     <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      overrun_err  <= 1'b0;
      rts_n        <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_q    <= rx_s;

      // Held at 0 in IDLE so the divider phase starts fresh on entry to START.
      if (state == IDLE || div_cnt == DW'(DIV - 1))
        div_cnt <= '0;
      else
        div_cnt <= div_cnt + DW'(1);

      if (tick)
        tcnt <= tcnt + 4'd1;

      case (state)
        IDLE: begin
          tcnt <= 4'd0;
          if (rx_q && !rx_s)
            state <= START;
        end
        START: begin
          if (tick && tcnt == 4'd7) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              data_bits_sh <= data_bit_num;
              stop2_sh     <= stop_bit_num;
              par_en_sh    <= parity_en;
              par_type_sh  <= parity_type;
              tcnt         <= 4'd0;
              bit_cnt      <= 3'd0;
              shift        <= 8'd0;
              parity_bad   <= 1'b0;
              frame_bad    <= 1'b0;
              state        <= DATA;
            end
          end
        end
        DATA: begin
          if (sample) begin
            shift[bit_cnt] <= rx_s;
            bit_cnt        <= bit_cnt + 3'd1;
            if (bit_cnt == last_idx)
              state <= par_en_sh ? PARITY : STOP1;
          end
        end
        PARITY: begin
          if (sample) begin
            parity_bad <= rx_s ^ par_expected;
            state      <= STOP1;
          end
        end
        STOP1: begin
          if (sample) begin
            if (stop2_sh) begin
              frame_bad <= ~rx_s;
              state     <= STOP2;
            end else begin
              state <= IDLE;
            end
          end
        end
        STOP2: begin
          if (sample)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Holding register: a completing frame loads if the slot is empty or
      // being emptied this cycle, otherwise it is dropped as an overrun.
      if (complete) begin
        if (!rx_valid || rx_ready) begin
          rx_data     <= shift;
          parity_err  <= parity_bad;
          frame_err   <= frame_new;
          rx_valid    <= 1'b1;
          rts_n       <= 1'b1;
          overrun_err <= 1'b0;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid    <= 1'b0;
        rts_n       <= 1'b0;
        parity_err  <= 1'b0;
        frame_err   <= 1'b0;
        overrun_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed, table-driven bench for uart_rx at DIV = 10
// (160 clk per bit), plus hand-written sequences for glitch, break,
// overrun, mid-frame configuration change and mid-frame reset.
module tb_uart_rx;

  localparam int BIT_CLK = 160;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic [1:0] data_bit_num = 2'd3;
  logic       stop_bit_num = 1'b0;
  logic       parity_en = 1'b0;
  logic       parity_type = 1'b0;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun_err;
  logic       rts_n;

  uart_rx #(
    .BAUD_RATE    (115200),
    .FREQUENCY_CLK(18432000)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx          (rx),
    .data_bit_num(data_bit_num),
    .stop_bit_num(stop_bit_num),
    .parity_en   (parity_en),
    .parity_type (parity_type),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .rts_n       (rts_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Records the cycle in which rx_valid is first seen high after being armed.
  int   rise_cyc = -1;
  logic prev_valid = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rx_valid && !prev_valid && rise_cyc < 0)
        rise_cyc = cyc;
      prev_valid = rx_valid;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int fall_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT_CLK) @(posedge clk);
    #1;
  endtask

  // Call at #1 after a posedge. Format is read once at the start.
  task automatic send_frame(input logic [7:0] d, input bit flip, input logic [1:0] stop_low);
    int   n;
    logic p;
    logic pen;
    logic ptype;
    logic two;
    n     = 5 + int'(data_bit_num);
    pen   = parity_en;
    ptype = parity_type;
    two   = stop_bit_num;
    fall_cyc = cyc;
    send_bit(1'b0);
    p = 1'b0;
    for (int i = 0; i < n; i++) begin
      send_bit(d[i]);
      p = p ^ d[i];
    end
    if (pen) begin
      if (!ptype) p = ~p;
      send_bit(p ^ flip);
    end
    send_bit(~stop_low[0]);
    if (two) send_bit(~stop_low[1]);
    rx = 1'b1;
  endtask

  task automatic pop(input string tag);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    check({tag, " pop valid"}, rx_valid, 0);
    check({tag, " pop rts_n"}, rts_n, 0);
    check({tag, " pop flags"}, {parity_err, frame_err, overrun_err}, 0);
  endtask

  typedef struct {
    logic [1:0] dbits;
    logic       stop2;
    logic       pen;
    logic       ptype;
    logic [7:0] data;
    bit         flip;
    logic [1:0] stop_low;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int lat;
    //          dbits stop2 pen  ptype data  flip  stop_low exp_data perr  ferr
    vecs[0] = '{2'd3, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 2'b00, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{2'd2, 1'b1, 1'b1, 1'b1, 8'h53, 1'b0, 2'b00, 8'h53, 1'b0, 1'b0};
    vecs[2] = '{2'd2, 1'b1, 1'b1, 1'b1, 8'h53, 1'b1, 2'b00, 8'h53, 1'b1, 1'b0};
    vecs[3] = '{2'd0, 1'b0, 1'b1, 1'b0, 8'h1F, 1'b0, 2'b00, 8'h1F, 1'b0, 1'b0};
    vecs[4] = '{2'd0, 1'b0, 1'b1, 1'b0, 8'h1F, 1'b0, 2'b01, 8'h1F, 1'b0, 1'b1};
    vecs[5] = '{2'd1, 1'b0, 1'b0, 1'b0, 8'h2A, 1'b0, 2'b00, 8'h2A, 1'b0, 1'b0};
    vecs[6] = '{2'd3, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0};
    vecs[7] = '{2'd3, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 2'b10, 8'hFF, 1'b0, 1'b1};
    vecs[8] = '{2'd0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 2'b00, 8'h1F, 1'b0, 1'b0};
    vecs[9] = '{2'd1, 1'b1, 1'b0, 1'b0, 8'h15, 1'b0, 2'b01, 8'h15, 1'b0, 1'b1};

    // Reset state
    repeat (5) @(posedge clk);
    #1;
    check("reset rx_data", rx_data, 0);
    check("reset rx_valid", rx_valid, 0);
    check("reset flags", {parity_err, frame_err, overrun_err}, 0);
    check("reset rts_n", rts_n, 0);
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // Table-driven frames
    for (int v = 0; v < 10; v++) begin
      data_bit_num = vecs[v].dbits;
      stop_bit_num = vecs[v].stop2;
      parity_en    = vecs[v].pen;
      parity_type  = vecs[v].ptype;
      rise_cyc     = -1;
      send_frame(vecs[v].data, vecs[v].flip, vecs[v].stop_low);
      // 2 sync cycles + last stop sample + 1 register stage
      lat = 2 + (8 + 16 * (5 + int'(vecs[v].dbits) + int'(vecs[v].pen) + 1 + int'(vecs[v].stop2))) * 10 + 1;
      $display("[TB] vec %0d rx_data=%02h perr=%0b ferr=%0b ovr=%0b latency=%0d",
               v, rx_data, parity_err, frame_err, overrun_err, rise_cyc - fall_cyc);
      check($sformatf("vec%0d valid", v), rx_valid, 1);
      check($sformatf("vec%0d data", v), rx_data, vecs[v].exp_data);
      check($sformatf("vec%0d parity_err", v), parity_err, vecs[v].exp_perr);
      check($sformatf("vec%0d frame_err", v), frame_err, vecs[v].exp_ferr);
      check($sformatf("vec%0d overrun_err", v), overrun_err, 0);
      check($sformatf("vec%0d rts_n", v), rts_n, 1);
      check($sformatf("vec%0d latency", v), rise_cyc - fall_cyc, lat);
      pop($sformatf("vec%0d", v));
    end

    data_bit_num = 2'd3;
    stop_bit_num = 1'b0;
    parity_en    = 1'b0;
    parity_type  = 1'b0;

    // Glitch: 50-clk low pulse must not produce a character
    rise_cyc = -1;
    rx = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    $display("[TB] glitch rx_valid=%0b", rx_valid);
    check("glitch no valid", rx_valid, 0);
    check("glitch no rise", rise_cyc, -1);
    send_frame(8'h5A, 1'b0, 2'b00);
    $display("[TB] after glitch rx_data=%02h", rx_data);
    check("after glitch valid", rx_valid, 1);
    check("after glitch data", rx_data, 8'h5A);
    pop("after glitch");

    // Configuration changes mid-frame are ignored by the current frame
    fork
      send_frame(8'hC3, 1'b0, 2'b00);
      begin
        repeat (400) @(posedge clk);
        #1;
        data_bit_num = 2'd0;
        parity_en    = 1'b1;
        stop_bit_num = 1'b1;
      end
    join
    $display("[TB] cfg change rx_data=%02h perr=%0b ferr=%0b", rx_data, parity_err, frame_err);
    check("cfg change data", rx_data, 8'hC3);
    check("cfg change flags", {rx_valid, parity_err, frame_err}, 3'b100);
    pop("cfg change");
    data_bit_num = 2'd3;
    stop_bit_num = 1'b0;
    parity_en    = 1'b0;

    // Break: line held low through the stop bit
    rx = 1'b0;
    repeat (1800) @(posedge clk);
    #1;
    $display("[TB] break rx_data=%02h ferr=%0b", rx_data, frame_err);
    check("break valid", rx_valid, 1);
    check("break data", rx_data, 0);
    check("break frame_err", frame_err, 1);
    check("break parity_err", parity_err, 0);
    pop("break");
    repeat (500) @(posedge clk);
    #1;
    check("break no restart", rx_valid, 0);
    rx = 1'b1;
    repeat (50) @(posedge clk);
    #1;

    // Overrun: second back-to-back frame dropped
    send_frame(8'h11, 1'b0, 2'b00);
    send_frame(8'h22, 1'b0, 2'b00);
    $display("[TB] overrun rx_data=%02h ovr=%0b", rx_data, overrun_err);
    check("overrun valid", rx_valid, 1);
    check("overrun data", rx_data, 8'h11);
    check("overrun flag", overrun_err, 1);
    pop("overrun");

    // Ready in the completion cycle of frame 2: frame 2 loads
    fork
      begin
        send_frame(8'h11, 1'b0, 2'b00);
        send_frame(8'h22, 1'b0, 2'b00);
      end
      begin
        repeat (10 * BIT_CLK + 1522) @(posedge clk);
        #1;
        check("same-cycle pre data", rx_data, 8'h11);
        check("same-cycle pre overrun", overrun_err, 0);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        $display("[TB] same-cycle load rx_data=%02h ovr=%0b", rx_data, overrun_err);
        check("same-cycle valid", rx_valid, 1);
        check("same-cycle data", rx_data, 8'h22);
        check("same-cycle overrun", overrun_err, 0);
      end
    join

    // Reset at mid data bit 3 with a character still held
    fork
      send_frame(8'h3C, 1'b0, 2'b00);
      begin
        repeat (4 * BIT_CLK + 80) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #2;
        $display("[TB] mid-frame reset rx_valid=%0b rx_data=%02h", rx_valid, rx_data);
        check("midreset rx_data", rx_data, 0);
        check("midreset rx_valid", rx_valid, 0);
        check("midreset flags", {parity_err, frame_err, overrun_err}, 0);
        check("midreset rts_n", rts_n, 0);
      end
    join
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("post reset idle", rx_valid, 0);
    send_frame(8'h3C, 1'b0, 2'b00);
    $display("[TB] after reset rx_data=%02h", rx_data);
    check("after reset valid", rx_valid, 1);
    check("after reset data", rx_data, 8'h3C);
    check("after reset flags", {parity_err, frame_err, overrun_err}, 0);
    pop("after reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
